// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Multi-cycle sequencer for the 4-bit-opcode datapath (add/addi/st/ld).
//   Owns the program counter and instruction register. It also arbitrates the
//   single shared memory port between instruction fetch and ld/st data access.
//   Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB. All control
//   outputs are Moore outputs, decoded from the registered state and ir only.
//
// Ports
//   clk        in   1        rising-edge system clock
//   rst_n      in   1        synchronous active-low reset
//   start      in   1        leave IDLE/HALT and begin fetching
//   mem_rdata  in   INSTR_W  memory read data (instruction fetch)
//   mem_ack    in   1        memory access complete (may arrive with mem_req)
//   mem_req    out  1        memory access request
//   mem_addr   out  ADDR_W   memory address (pc in FETCH, ir[7:0] in MEM)
//   m_wr_en    out  1        memory write enable (st only)
//   pc         out  ADDR_W   program counter
//   ir         out  INSTR_W  instruction register
//   wr_en      out  1        register-file write enable
//   alu_op     out  1        ALU add select
//   e_rd_en    out  1        immediate read enable
//   sel1       out  1        ALU operand B mux, 1 = immediate
//   sel2       out  1        write-back mux, 1 = memory data
//   halted     out  1        controller is in HALT
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               m_wr_en,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               wr_en,
    output logic               alu_op,
    output logic               e_rd_en,
    output logic               sel1,
    output logic               sel2,
    output logic               halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [3:0]          w_op;
    logic [ADDR_W-1:0]   w_dataAddr;

    assign w_op       = r_ir[INSTR_W-1 -: 4];
    // The 8-bit address field is zero-extended or truncated to the port width.
    assign w_dataAddr = ADDR_W'(r_ir[7:0]);

    assign pc = r_pc;
    assign ir = r_ir;

    // State, PC and IR registers. The fetch only completes on mem_ack while in
    // FETCH, so an ack that arrives in any other state cannot disturb ir or pc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == FETCH && mem_ack) begin
                r_ir <= mem_rdata;
                r_pc <= r_pc + ADDR_W'(1);
            end
        end
    end

    // Next-state logic and Moore output decode from the registered state/ir.
    always_comb begin
        w_nextState = r_state;
        mem_req     = 1'b0;
        mem_addr    = '0;
        m_wr_en     = 1'b0;
        wr_en       = 1'b0;
        alu_op      = 1'b0;
        e_rd_en     = 1'b0;
        sel1        = 1'b0;
        sel2        = 1'b0;
        halted      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) w_nextState = FETCH;
            end

            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = r_pc;
                if (mem_ack) w_nextState = DECODE;
            end

            DECODE: begin
                case (w_op)
                    OP_ADD, OP_ADDI: w_nextState = EXEC;
                    OP_ST, OP_LD:    w_nextState = MEM;
                    OP_HALT:         w_nextState = HALT;
                    default:         w_nextState = FETCH;
                endcase
            end

            EXEC: begin
                alu_op = 1'b1;
                if (w_op == OP_ADDI) begin
                    sel1    = 1'b1;
                    e_rd_en = 1'b1;
                end
                w_nextState = WB;
            end

            MEM: begin
                mem_req  = 1'b1;
                mem_addr = w_dataAddr;
                m_wr_en  = (w_op == OP_ST);
                if (mem_ack) begin
                    w_nextState = (w_op == OP_ST) ? FETCH : WB;
                end
            end

            WB: begin
                wr_en = 1'b1;
                case (w_op)
                    OP_ADD: alu_op = 1'b1;
                    OP_ADDI: begin
                        alu_op  = 1'b1;
                        sel1    = 1'b1;
                        e_rd_en = 1'b1;
                    end
                    OP_LD:   sel2 = 1'b1;
                    default: ;
                endcase
                w_nextState = FETCH;
            end

            HALT: begin
                halted = 1'b1;
                if (start) w_nextState = FETCH;
            end

            default: w_nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed self-checking bench for multi_cycle_ctrl. A small memory model
//   answers requests after a programmable number of wait cycles. Control
//   outputs are packed as
//   {mem_req, m_wr_en, wr_en, alu_op, e_rd_en, sel1, sel2, halted}
//   and compared against hand-computed values one cycle at a time.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        m_wr_en;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        wr_en;
    logic        alu_op;
    logic        e_rd_en;
    logic        sel1;
    logic        sel2;
    logic        halted;

    logic [15:0] mem [256];
    int          ackDelay   = 0;
    logic        forceAck   = 1'b0;
    int          waitCnt    = 0;
    int          stCount    = 0;
    logic [7:0]  lastWrAddr = '0;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] ctl;
    assign ctl = {mem_req, m_wr_en, wr_en, alu_op, e_rd_en, sel1, sel2, halted};

    multi_cycle_ctrl #(.INSTR_W(16), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .m_wr_en   (m_wr_en),
        .pc        (pc),
        .ir        (ir),
        .wr_en     (wr_en),
        .alu_op    (alu_op),
        .e_rd_en   (e_rd_en),
        .sel1      (sel1),
        .sel2      (sel2),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read data; ack once the request has waited
    // ackDelay cycles. forceAck injects a stray ack regardless of mem_req.
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = forceAck || (mem_req && (waitCnt >= ackDelay));

    // Wait-cycle counter and a log of completed store accesses.
    always @(posedge clk) begin
        if (!mem_req || mem_ack) waitCnt <= 0;
        else                     waitCnt <= waitCnt + 1;
        if (mem_req && mem_ack && m_wr_en) begin
            stCount    <= stCount + 1;
            lastWrAddr <= mem_addr;
        end
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic rstVal, input logic startVal);
        rst_n = rstVal;
        start = startVal;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0);
    endtask

    initial begin
        int stBefore;
        clearMem();
        applyStimulus(1'b0, 1'b0);

        // 1. Reset and idle
        $display("[TB] test 1: reset/idle");
        doReset();
        for (int i = 0; i < 5; i++) tick();
        checkOutput("t1_pc",  32'(pc),  32'h0);
        checkOutput("t1_ir",  32'(ir),  32'h0);
        checkOutput("t1_ctl", 32'(ctl), 32'h00);

        // 2. add, zero-wait, followed by halt
        $display("[TB] test 2: add zero-wait");
        clearMem();
        mem[0] = 16'h1100;
        mem[1] = 16'hF000;
        ackDelay = 0;
        doReset();
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2_c1_ctl",  32'(ctl),      32'h80);
        checkOutput("t2_c1_addr", 32'(mem_addr), 32'h00);
        tick();
        checkOutput("t2_c2_ctl",  32'(ctl), 32'h00);
        checkOutput("t2_c2_ir",   32'(ir),  32'h1100);
        checkOutput("t2_c2_pc",   32'(pc),  32'h01);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2_c3_ctl",  32'(ctl), 32'h10);
        tick();
        checkOutput("t2_c4_ctl",  32'(ctl), 32'h30);
        tick();
        checkOutput("t2_c5_ctl",  32'(ctl),      32'h80);
        checkOutput("t2_c5_addr", 32'(mem_addr), 32'h01);
        tick();
        checkOutput("t2_c6_ir",   32'(ir),  32'hF000);
        tick();
        checkOutput("t2_c7_ctl",  32'(ctl), 32'h01);
        checkOutput("t2_c7_pc",   32'(pc),  32'h02);

        // 3. addi with three wait cycles on the fetch
        $display("[TB] test 3: addi with ack delay");
        clearMem();
        mem[0] = 16'h2105;
        mem[1] = 16'hF000;
        ackDelay = 3;
        doReset();
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_fetch%0d_ctl", i),  32'(ctl),      32'h80);
            checkOutput($sformatf("t3_fetch%0d_addr", i), 32'(mem_addr), 32'h00);
            tick();
        end
        checkOutput("t3_dec_ir",  32'(ir),  32'h2105);
        checkOutput("t3_dec_ctl", 32'(ctl), 32'h00);
        tick();
        checkOutput("t3_exec_ctl", 32'(ctl), 32'h1C);
        tick();
        checkOutput("t3_wb_ctl",   32'(ctl), 32'h3C);
        ackDelay = 0;
        tick();
        checkOutput("t3_c8_ctl",  32'(ctl),      32'h80);
        checkOutput("t3_c8_addr", 32'(mem_addr), 32'h01);

        // 4. st then ld on address 0x40
        $display("[TB] test 4: st then ld");
        clearMem();
        mem[0] = 16'h3140;
        mem[1] = 16'h4240;
        mem[2] = 16'hF000;
        ackDelay = 0;
        doReset();
        stBefore = stCount;
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("t4_c1_addr", 32'(mem_addr), 32'h00);
        tick();
        checkOutput("t4_c2_ir",   32'(ir),  32'h3140);
        tick();
        checkOutput("t4_st_ctl",  32'(ctl),      32'hC0);
        checkOutput("t4_st_addr", 32'(mem_addr), 32'h40);
        tick();
        checkOutput("t4_c4_ctl",  32'(ctl),      32'h80);
        checkOutput("t4_c4_addr", 32'(mem_addr), 32'h01);
        checkOutput("t4_stcount", 32'(stCount - stBefore), 32'd1);
        checkOutput("t4_wraddr",  32'(lastWrAddr), 32'h40);
        tick();
        checkOutput("t4_c5_ir",   32'(ir),  32'h4240);
        tick();
        checkOutput("t4_ld_ctl",  32'(ctl),      32'h80);
        checkOutput("t4_ld_addr", 32'(mem_addr), 32'h40);
        tick();
        checkOutput("t4_wb_ctl",  32'(ctl), 32'h22);
        tick();
        checkOutput("t4_c8_addr", 32'(mem_addr), 32'h02);
        checkOutput("t4_stcount_after", 32'(stCount - stBefore), 32'd1);

        // 5. Run NOPs up to 0xFF, halt there, PC wraps to 0, then resume
        $display("[TB] test 5: halt and pc wrap");
        clearMem();
        mem[255] = 16'hF000;
        ackDelay = 0;
        doReset();
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 1000 && !halted; i++) tick();
        checkOutput("t5_halted", 32'(halted), 32'h1);
        checkOutput("t5_pc",     32'(pc),     32'h00);
        checkOutput("t5_ir",     32'(ir),     32'hF000);
        tick();
        checkOutput("t5_hold_ctl", 32'(ctl), 32'h01);
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        checkOutput("t5_resume_ctl",  32'(ctl),      32'h80);
        checkOutput("t5_resume_addr", 32'(mem_addr), 32'h00);

        // 6. Reset in the middle of a fetch, then a late ack
        $display("[TB] test 6: reset mid-fetch");
        clearMem();
        mem[0] = 16'h1100;
        ackDelay = 100;
        doReset();
        applyStimulus(1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("t6_pending_ctl", 32'(ctl), 32'h80);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkOutput("t6_rst_ctl", 32'(ctl), 32'h00);
        applyStimulus(1'b1, 1'b0);
        forceAck = 1'b1;
        tick();
        forceAck = 1'b0;
        checkOutput("t6_late_ir",  32'(ir),  32'h0);
        checkOutput("t6_late_ctl", 32'(ctl), 32'h00);
        tick();
        checkOutput("t6_idle_ctl", 32'(ctl), 32'h00);
        checkOutput("t6_idle_pc",  32'(pc),  32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
